// File: rtl/dmem_bus_if_pkg.sv
// Shared types and constants for the data-memory bus adapter.
package dmem_bus_if_pkg;

  localparam int                   REG_BUS_W   = 32;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD   = '0;
  localparam logic                 CHIP_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    DMEM_IDLE  = 3'd0,
    DMEM_REQ   = 3'd1,
    DMEM_WAIT  = 3'd2,
    DMEM_DONE  = 3'd3,
    DMEM_DRAIN = 3'd4
  } dmem_state_e;

  // An access is in flight on the bus while requesting or awaiting read data.
  function automatic logic in_flight(dmem_state_e s);
    return (s == DMEM_REQ) || (s == DMEM_WAIT);
  endfunction

endpackage

// File: rtl/dmem_watchdog.sv
`ifdef DMEM_TIMEOUT_EN
// dmem_watchdog: counts cycles while run_i is high and clears when low; expired_o is asserted
// combinationally in the TIMEOUT_CYCLES-th running cycle. Present only with DMEM_TIMEOUT_EN.
module dmem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: MEM-stage to req/gnt/rvalid bus adapter; loads stall >=3 cycles, stores >=2.
// Holds MEM via stallreq_o, keeps bus_* stable until gnt, honours stall_i in DONE; DMEM_TIMEOUT_EN adds a watchdog.
module dmem_bus_if
  import dmem_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
);

  dmem_state_e          state_q, state_d;
  logic                 we_q, we_d;
  logic [REG_BUS_W-1:0] addr_q, addr_d;
  logic [REG_BUS_W-1:0] wdata_q, wdata_d;
  logic [REG_BUS_W-1:0] rdata_q, rdata_d;
  logic [3:0]           sel_q, sel_d;
  logic                 err_q, err_d;
  logic                 timeout;

`ifdef DMEM_TIMEOUT_EN
  dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .run_i    (in_flight(state_q)),
    .expired_o(timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0) ^ (CNT_W != 0);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    bus_req_o  = 1'b0;
    stallreq_o = in_flight(state_q);

    case (state_q)
      DMEM_IDLE: begin
        stallreq_o = mem_ce_i;
        if (mem_ce_i == CHIP_ENABLE && !flush_i) begin
          we_d    = mem_we_i;
          addr_d  = mem_addr_i;
          sel_d   = mem_sel_i;
          wdata_d = mem_data_i;
          state_d = DMEM_REQ;
        end
      end
      DMEM_REQ: begin
        bus_req_o = 1'b1;
        // A store is committed at grant, so a flush then has nothing left to undo.
        if (flush_i) begin
          state_d = (bus_gnt_i && !we_q) ? DMEM_DRAIN : DMEM_IDLE;
        end else if (bus_gnt_i) begin
          state_d = we_q ? DMEM_DONE : DMEM_WAIT;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = ZERO_WORD;
          state_d = DMEM_DONE;
        end
      end
      DMEM_WAIT: begin
        // A response arriving with the flush is already consumed; no drain needed.
        if (flush_i) begin
          state_d = bus_rvalid_i ? DMEM_IDLE : DMEM_DRAIN;
        end else if (bus_rvalid_i) begin
          rdata_d = bus_rdata_i;
          state_d = DMEM_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = ZERO_WORD;
          state_d = DMEM_DONE;
        end
      end
      DMEM_DONE: begin
        if (flush_i || !stall_i) state_d = DMEM_IDLE;
      end
      DMEM_DRAIN: begin
        if (bus_rvalid_i) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DMEM_IDLE;
      we_q    <= 1'b0;
      addr_q  <= ZERO_WORD;
      sel_q   <= 4'b0;
      wdata_q <= ZERO_WORD;
      rdata_q <= ZERO_WORD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_data_o  = rdata_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_sel_o   = sel_q;
  assign bus_wdata_o = wdata_q;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Bench for dmem_bus_if: directed scenarios plus randomized accesses against a transaction-level model.
module tb_dmem_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i, stall_i, flush_i;
  logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
  logic [3:0]  mem_sel_i;
  logic        stallreq_o, bus_req_o, bus_we_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;
  logic        bus_gnt_i, bus_rvalid_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_bus_if #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ce_i    (mem_ce_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sel_i   (mem_sel_i),
    .mem_data_i  (mem_data_i),
    .mem_data_o  (mem_data_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .stallreq_o  (stallreq_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_sel_o   (bus_sel_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_gnt_i   (bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i (bus_rdata_i),
    .bus_err_o   (bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    mem_ce_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic present(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd);
    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wd;
  endtask

  // One access starting in IDLE: the bench plays the bus (gnt after gdly request cycles,
  // rvalid rdly cycles after the first WAIT cycle) and holds stall_i for sdly DONE cycles.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd, input int gdly,
                        input int rdly, input logic [31:0] rd, input int sdly, input bit junk);
    int stall_cnt, req_cnt, gnt_cnt, wait_cnt, done_cnt, err_cnt, cyc, fld_bad, dat_bad;
    bit granted, got, fin;
    logic [31:0] exp_dat;
    stall_cnt = 0; req_cnt = 0; gnt_cnt = 0; wait_cnt = 0; done_cnt = 0;
    err_cnt = 0; cyc = 0; fld_bad = 0; dat_bad = 0;
    granted = 0; got = 0; fin = 0;
    exp_dat = we ? model_rdata : rd;
    @(negedge clk);
    present(we, addr, sel, wd);
    while (!fin && cyc < 100) begin
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom; stall_i = 1'b0;
      if (bus_req_o) begin
        if (bus_we_o !== we || bus_addr_o !== addr || bus_sel_o !== sel || bus_wdata_o !== wd)
          fld_bad++;
        if (req_cnt == gdly) begin
          bus_gnt_i = 1'b1; gnt_cnt++; granted = 1;
        end else if (junk) begin
          bus_rvalid_i = 1'b1;
        end
        req_cnt++;
      end else if (granted && !we && !got) begin
        if (wait_cnt == rdly) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = rd; got = 1;
        end
        wait_cnt++;
      end
      #1;
      if (bus_err_o) err_cnt++;
      if (stallreq_o) begin
        stall_cnt++;
      end else if (cyc > 0) begin
        if (mem_data_o !== exp_dat || bus_req_o !== 1'b0) dat_bad++;
        stall_i = (done_cnt < sdly);
        done_cnt++;
        if (!stall_i) fin = 1;
      end
      cyc++;
      if (!fin) @(negedge clk);
    end
    if (!we) model_rdata = rd;
    check({tag, "_finished"}, 32'(fin), 32'd1);
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(1 + (gdly + 1) + (we ? 0 : rdly + 1)));
    check({tag, "_req_cycles"}, 32'(req_cnt), 32'(gdly + 1));
    check({tag, "_gnt_count"}, 32'(gnt_cnt), 32'd1);
    check({tag, "_fields_unstable"}, 32'(fld_bad), 32'd0);
    check({tag, "_done_data_bad"}, 32'(dat_bad), 32'd0);
    check({tag, "_done_cycles"}, 32'(done_cnt), 32'(sdly + 1));
    check({tag, "_err_pulses"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    logic        r_we;
    logic [31:0] r_addr, r_wd, r_rd;
    logic [3:0]  r_sel;

    rst = 1'b1; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0;
    mem_data_i = '0; stall_i = 1'b0; flush_i = 1'b0; bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    #3 rst = 1'b0;
    #1;
    check("rst_stallreq", 32'(stallreq_o), 32'd0);
    check("rst_bus_req", 32'(bus_req_o), 32'd0);
    check("rst_mem_data", mem_data_o, 32'h0);
    check("rst_bus_addr", bus_addr_o, 32'h0);
    check("rst_bus_we_sel", {27'b0, bus_we_o, bus_sel_o}, 32'h0);
    check("rst_bus_wdata", bus_wdata_o, 32'h0);
    check("rst_bus_err", 32'(bus_err_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    access("t1_load", 1'b0, 32'h100, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);
    access("t2_store", 1'b1, 32'h204, 4'b0011, 32'h12341234, 4, 0, 32'h0, 0, 1);
    access("t3_stall", 1'b0, 32'h208, 4'hF, 32'h0, 1, 1, 32'h5A5A1234, 3, 0);

    // Flush while waiting for read data; the late response must be discarded.
    @(negedge clk); present(1'b0, 32'h400, 4'hF, 32'h0);
    @(negedge clk); check("fw_req", 32'(bus_req_o), 32'd1); bus_gnt_i = 1'b1;
    @(negedge clk); bus_gnt_i = 1'b0; flush_i = 1'b1; mem_ce_i = 1'b0;
    #1 check("fw_wait_stall", 32'(stallreq_o), 32'd1);
    @(negedge clk); flush_i = 1'b0; present(1'b1, 32'h40C, 4'hC, 32'h77660000);
    #1 check("fw_drain1_stall", 32'(stallreq_o), 32'd0);
    check("fw_drain1_req", 32'(bus_req_o), 32'd0);
    @(negedge clk); bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
    #1 check("fw_drain2_stall", 32'(stallreq_o), 32'd0);
    check("fw_drain2_data", mem_data_o, model_rdata);
    access("t4_after", 1'b1, 32'h40C, 4'hC, 32'h77660000, 0, 0, 32'h0, 0, 0);

    // Flush of an ungranted request.
    @(negedge clk); present(1'b0, 32'h500, 4'hF, 32'h0);
    @(negedge clk); check("fr_req", 32'(bus_req_o), 32'd1); flush_i = 1'b1; mem_ce_i = 1'b0;
    @(negedge clk); flush_i = 1'b0;
    #1 check("fr_req_drop", 32'(bus_req_o), 32'd0);
    check("fr_stall", 32'(stallreq_o), 32'd0);
    access("t5_after", 1'b0, 32'h504, 4'hF, 32'h0, 2, 0, 32'h0BADF00D, 0, 0);

    // Flush in the same cycle a load is granted: drain the response.
    @(negedge clk); present(1'b0, 32'h600, 4'hF, 32'h0);
    @(negedge clk); bus_gnt_i = 1'b1; flush_i = 1'b1; mem_ce_i = 1'b0;
    @(negedge clk); bus_gnt_i = 1'b0; flush_i = 1'b0; present(1'b1, 32'h604, 4'h1, 32'h00000099);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h13579BDF;
    #1 check("fg_drain_stall", 32'(stallreq_o), 32'd0);
    check("fg_drain_req", 32'(bus_req_o), 32'd0);
    access("t6_after", 1'b1, 32'h604, 4'h1, 32'h00000099, 0, 0, 32'h0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_addr = $urandom & 32'hFFFF_FFFC;
      r_sel  = 4'($urandom_range(1, 15));
      r_wd   = $urandom;
      r_rd   = $urandom;
      access("rnd", r_we, r_addr, r_sel, r_wd, $urandom_range(0, 3), $urandom_range(0, 2),
             r_rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

`ifdef DMEM_TIMEOUT_EN
    begin : timeout_blk
      int n;
      n = 0;
      @(negedge clk); present(1'b0, 32'h700, 4'hF, 32'h0);
      @(negedge clk);
      while (bus_req_o && n < 20) begin
        n++;
        @(negedge clk);
      end
      #1;
      check("to_req_cycles", 32'(n), 32'd8);
      check("to_err", 32'(bus_err_o), 32'd1);
      check("to_data", mem_data_o, 32'h0);
      check("to_stall", 32'(stallreq_o), 32'd0);
      stall_i = 1'b1;
      @(negedge clk); #1;
      check("to_err_pulse", 32'(bus_err_o), 32'd0);
      check("to_hold_stall", 32'(stallreq_o), 32'd0);
      stall_i = 1'b0;
      model_rdata = 32'h0;
      idle();
    end
`endif

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk); present(1'b0, 32'h300, 4'hA, 32'h0);
    @(negedge clk); check("rw_req", 32'(bus_req_o), 32'd1); bus_gnt_i = 1'b1;
    @(negedge clk); bus_gnt_i = 1'b0; mem_ce_i = 1'b0; rst = 1'b0;
    #1;
    check("rw_stallreq", 32'(stallreq_o), 32'd0);
    check("rw_bus_req", 32'(bus_req_o), 32'd0);
    check("rw_mem_data", mem_data_o, 32'h0);
    check("rw_bus_addr", bus_addr_o, 32'h0);
    check("rw_bus_we_sel", {27'b0, bus_we_o, bus_sel_o}, 32'h0);
    check("rw_bus_err", 32'(bus_err_o), 32'd0);
    @(negedge clk); rst = 1'b1;
    model_rdata = 32'h0;
    access("t7_post_rst", 1'b1, 32'h310, 4'hF, 32'hA5A5A5A5, 1, 0, 32'h0, 1, 0);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no completion, required finish (%0d checks, %0d errors)",
             checks, errors);
    $fatal(1);
  end

endmodule
